// File: rtl/mig_app_arbiter.sv
// Two-port round-robin arbiter in front of a MIG DDR3 user interface.
// One transaction in flight at a time; port 0 is read-only, port 1 may read or write.
module mig_app_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16
) (
    input  logic                  ui_clk,
    input  logic                  sys_rst,
    input  logic                  init_calib_complete,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic                  p1_we,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    input  logic [MASK_WIDTH-1:0] p1_wmask,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic [ADDR_WIDTH-1:0] app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    input  logic                  app_rdy,
    output logic [DATA_WIDTH-1:0] app_wdf_data,
    output logic [MASK_WIDTH-1:0] app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_wdf_rdy,
    input  logic                  app_rd_data_valid,
    input  logic [DATA_WIDTH-1:0] app_rd_data,
    output logic                  busy,
    output logic                  err_stray
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_DONE} state_t;

    state_t                r_state;
    logic                  r_last_gnt;
    logic                  r_gnt;
    logic                  r_is_rd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_cmd;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [MASK_WIDTH-1:0] r_wmask;
    logic                  r_app_en;
    logic                  r_wren;
    logic                  r_p0_done;
    logic                  r_p1_done;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;
    logic                  r_busy;
    logic                  r_err;

    logic w_elig0, w_elig1, w_pick1;
    logic w_cmd_acc, w_wdf_acc, w_cmd_left, w_wdf_left, w_rd_ok;

    // A port whose done pulse is up this cycle is not allowed to re-win immediately.
    assign w_elig0    = p0_req & ~r_p0_done;
    assign w_elig1    = p1_req & ~r_p1_done;
    assign w_pick1    = w_elig1 & (~w_elig0 | ~r_last_gnt);
    assign w_cmd_acc  = r_app_en & app_rdy;
    assign w_wdf_acc  = r_wren & app_wdf_rdy;
    assign w_cmd_left = r_app_en & ~app_rdy;
    assign w_wdf_left = r_wren & ~app_wdf_rdy;
    assign w_rd_ok    = (r_state == S_RD_WAIT) | ((r_state == S_ISSUE) & r_is_rd);

    always_ff @(posedge ui_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
            r_gnt      <= 1'b0;
            r_is_rd    <= 1'b1;
            r_addr     <= '0;
            r_cmd      <= 3'b001;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_app_en   <= 1'b0;
            r_wren     <= 1'b0;
            r_p0_done  <= 1'b0;
            r_p1_done  <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (app_rd_data_valid & ~w_rd_ok)
                r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (init_calib_complete & (w_elig0 | w_elig1)) begin
                        r_gnt      <= w_pick1;
                        r_last_gnt <= w_pick1;
                        r_addr     <= w_pick1 ? p1_addr : p0_addr;
                        r_is_rd    <= ~(w_pick1 & p1_we);
                        r_cmd      <= (w_pick1 & p1_we) ? 3'b000 : 3'b001;
                        if (w_pick1 & p1_we) begin
                            r_wdata <= p1_wdata;
                            r_wmask <= p1_wmask;
                        end
                        r_app_en   <= 1'b1;
                        r_wren     <= w_pick1 & p1_we;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_cmd_acc) r_app_en <= 1'b0;
                    if (w_wdf_acc) r_wren   <= 1'b0;
                    if (r_is_rd) begin
                        // Read data may already be valid in the command-accept cycle.
                        if (w_cmd_acc & app_rd_data_valid) begin
                            if (r_gnt) begin
                                r_p1_rdata <= app_rd_data;
                                r_p1_done  <= 1'b1;
                            end else begin
                                r_p0_rdata <= app_rd_data;
                                r_p0_done  <= 1'b1;
                            end
                            r_state <= S_DONE;
                        end else if (w_cmd_acc) begin
                            r_state <= S_RD_WAIT;
                        end
                    end else if (~w_cmd_left & ~w_wdf_left) begin
                        if (r_gnt) r_p1_done <= 1'b1;
                        else       r_p0_done <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        if (r_gnt) begin
                            r_p1_rdata <= app_rd_data;
                            r_p1_done  <= 1'b1;
                        end else begin
                            r_p0_rdata <= app_rd_data;
                            r_p0_done  <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_p0_done <= 1'b0;
                    r_p1_done <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign p0_done      = r_p0_done;
    assign p1_done      = r_p1_done;
    assign p0_rdata     = r_p0_rdata;
    assign p1_rdata     = r_p1_rdata;
    assign app_addr     = r_addr;
    assign app_cmd      = r_cmd;
    assign app_en       = r_app_en;
    assign app_wdf_data = r_wdata;
    assign app_wdf_mask = r_wmask;
    assign app_wdf_wren = r_wren;
    assign app_wdf_end  = r_wren;
    assign busy         = r_busy;
    assign err_stray    = r_err;

endmodule
